// File: rtl/qed_dup_if.sv
// qed_dup_if
// Bundles the fetch-side signals seen by the QED duplicate-mode controller.
//   master : fetch control. Drives qed_en, qed_switch, IF_stall and
//            ifu_qed_instruction. Observes the controller outputs.
//   slave  : qed_dup_ctrl. Observes the fetch signals. Drives exec_dup,
//            qed_hold, qed_ready and pending_cnt.
// Signals:
//   qed_en              enables switching into duplicate mode
//   qed_switch          early switch request
//   IF_stall            fetch stall (no insert/delete that cycle)
//   ifu_qed_instruction fetched instruction, opcode 7'h7f is a NOP
//   exec_dup            duplicate mode (to the QED instruction queue)
//   qed_hold            drain hold, ORed into IF_stall by integration
//   qed_ready           one-cycle "balanced and drained" pulse
//   pending_cnt         tracked queue occupancy
interface qed_dup_if;
    logic        qed_en;
    logic        qed_switch;
    logic        IF_stall;
    logic [31:0] ifu_qed_instruction;
    logic        exec_dup;
    logic        qed_hold;
    logic        qed_ready;
    logic [6:0]  pending_cnt;

    modport master (
        output qed_en, qed_switch, IF_stall, ifu_qed_instruction,
        input  exec_dup, qed_hold, qed_ready, pending_cnt
    );

    modport slave (
        input  qed_en, qed_switch, IF_stall, ifu_qed_instruction,
        output exec_dup, qed_hold, qed_ready, pending_cnt
    );
endinterface

// File: rtl/qed_dup_ctrl.sv
// qed_dup_ctrl
// Mode controller for the duplicate-execution side of the QED instruction
// queue. In ORIG it counts original instructions inserted into the queue.
// It switches to DUP on request or on threshold, and counts replays out of
// the queue. After the last replay it holds fetch for DRAIN_CYCLES in CHECK.
// It then pulses qed_ready and returns to ORIG.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    qed_dup_if.slave. Carries the fetch inputs (qed_en, qed_switch,
//          IF_stall, ifu_qed_instruction) and the outputs (exec_dup,
//          qed_hold, qed_ready, pending_cnt).
module qed_dup_ctrl #(
    parameter int MAX_PENDING  = 127,
    parameter int DUP_THRESH   = 16,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    qed_dup_if.slave   bus
);

    localparam logic [6:0] MAX_P   = 7'(MAX_PENDING);
    localparam logic [6:0] THRESH  = 7'(DUP_THRESH);
    localparam logic [3:0] DRAIN_L = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ORIG  = 2'd0,
        DUP   = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t     state_reg;
    logic [6:0] pending_reg;
    logic [3:0] drain_reg;
    logic       ready_reg;

    logic is_nop;
    logic ins_event;
    logic del_event;
    logic switch_req;

    // Only the opcode field matters here; the remaining bits are unused.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.ifu_qed_instruction[31:7];

    assign is_nop = (bus.ifu_qed_instruction[6:0] == 7'h7f);

    // These mirror the queue's own insert/delete rules. Keeping them
    // identical keeps pending_reg equal to queue occupancy.
    assign ins_event = (state_reg == ORIG) & ~bus.IF_stall & ~is_nop &
                       (pending_reg != MAX_P);
    assign del_event = (state_reg == DUP) & ~bus.IF_stall &
                       (pending_reg != 7'd0);

    // This uses the registered count. An insert in the same cycle still
    // lands in the queue, because exec_dup is 0 for that cycle.
    assign switch_req = bus.qed_en & (pending_reg != 7'd0) &
                        (bus.qed_switch | (pending_reg >= THRESH) |
                         (pending_reg == MAX_P));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ORIG;
            pending_reg <= 7'd0;
            drain_reg   <= 4'd0;
            ready_reg   <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                ORIG: begin
                    if (ins_event)
                        pending_reg <= pending_reg + 7'd1;
                    if (switch_req)
                        state_reg <= DUP;
                end
                DUP: begin
                    if (del_event) begin
                        pending_reg <= pending_reg - 7'd1;
                        if (pending_reg == 7'd1) begin
                            state_reg <= CHECK;
                            drain_reg <= DRAIN_L;
                        end
                    end
                end
                CHECK: begin
                    // The drain count runs regardless of stall. The pipeline
                    // empties on its own once fetch is held.
                    if (drain_reg == 4'd0) begin
                        state_reg <= ORIG;
                        ready_reg <= 1'b1;
                    end else begin
                        drain_reg <= drain_reg - 4'd1;
                    end
                end
                default: state_reg <= ORIG;
            endcase
        end
    end

    assign bus.exec_dup    = (state_reg == DUP);
    assign bus.qed_hold    = (state_reg == CHECK);
    assign bus.qed_ready   = ready_reg;
    assign bus.pending_cnt = pending_reg;

endmodule

// File: tb/tb_qed_dup_ctrl.sv
// tb_qed_dup_ctrl
// Directed, table-driven bench for qed_dup_ctrl with default parameters
// (MAX_PENDING=127, DUP_THRESH=16, DRAIN_CYCLES=5). Each table record holds
// the inputs driven during one cycle and the outputs expected in that same
// cycle. A hand-written sequence covers asynchronous reset in mid-DUP.
module tb_qed_dup_ctrl;

    localparam logic [31:0] OP  = 32'h0000_0013;
    localparam logic [31:0] NOP = 32'h0000_007f;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    qed_dup_if dup_bus ();

    qed_dup_ctrl #(
        .MAX_PENDING  (127),
        .DUP_THRESH   (16),
        .DRAIN_CYCLES (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dup_bus)
    );

    typedef struct {
        logic        en;
        logic        sw;
        logic        st;
        logic [31:0] instr;
        logic        ed;
        logic        hd;
        logic        rd;
        logic [6:0]  pc;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic en, input logic sw, input logic st,
                       input logic [31:0] instr, input logic ed,
                       input logic hd, input logic rd, input logic [6:0] pc);
        vec_t v;
        v.en = en; v.sw = sw; v.st = st; v.instr = instr;
        v.ed = ed; v.hd = hd; v.rd = rd; v.pc = pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic sw, input logic st,
                         input logic [31:0] instr);
        dup_bus.qed_en              = en;
        dup_bus.qed_switch          = sw;
        dup_bus.IF_stall            = st;
        dup_bus.ifu_qed_instruction = instr;
    endtask

    task automatic check_outs(input string tag, input logic ed, input logic hd,
                              input logic rd, input logic [6:0] pc);
        chk({tag, ".exec_dup"},    32'(dup_bus.exec_dup),    32'(ed));
        chk({tag, ".qed_hold"},    32'(dup_bus.qed_hold),    32'(hd));
        chk({tag, ".qed_ready"},   32'(dup_bus.qed_ready),   32'(rd));
        chk({tag, ".pending_cnt"}, 32'(dup_bus.pending_cnt), 32'(pc));
    endtask

    initial begin
        // Pattern for the mixed test: 0=fetch, 1=NOP, 2=stalled fetch.
        int kind [10] = '{0, 1, 0, 2, 0, 1, 2, 0, 1, 0};
        int mix_pc [10] = '{0, 1, 1, 2, 2, 3, 3, 3, 4, 4};

        // Threshold switch: 16 inserts, then 16 replays, drain, ready.
        for (int i = 0; i < 16; i++) add(1, 0, 0, OP, 0, 0, 0, 7'(i));
        add(1, 0, 0, NOP, 0, 0, 0, 16);
        for (int i = 0; i < 16; i++) add(1, 0, 0, OP, 1, 0, 0, 7'(16 - i));
        // Fetch during CHECK with hold unwired: no count change.
        for (int i = 0; i < 5; i++) add(1, 0, 0, OP, 0, 1, 0, 0);
        add(1, 0, 0, NOP, 0, 0, 1, 0);
        add(1, 0, 0, NOP, 0, 0, 0, 0);

        // Mixed NOPs and stalls, switch request, stall in DUP.
        for (int i = 0; i < 10; i++)
            add(1, 0, (kind[i] == 2), (kind[i] == 1) ? NOP : OP, 0, 0, 0, 7'(mix_pc[i]));
        add(1, 1, 0, NOP, 0, 0, 0, 5);
        add(1, 0, 0, OP,  1, 0, 0, 5);
        add(1, 0, 0, NOP, 1, 0, 0, 4);   // NOP replays as a delete
        add(1, 0, 1, OP,  1, 0, 0, 3);
        add(1, 0, 1, OP,  1, 0, 0, 3);
        add(0, 0, 0, OP,  1, 0, 0, 3);   // qed_en low in DUP: no effect
        add(1, 0, 0, OP,  1, 0, 0, 2);
        add(1, 0, 0, OP,  1, 0, 0, 1);   // last delete, two cycles late
        for (int i = 0; i < 5; i++) add(1, 0, 1, OP, 0, 1, 0, 0);
        add(1, 0, 0, NOP, 0, 0, 1, 0);
        add(1, 0, 0, NOP, 0, 0, 0, 0);

        // Switch with an empty queue is ignored; one insert then switch.
        add(1, 1, 0, NOP, 0, 0, 0, 0);
        add(1, 1, 1, OP,  0, 0, 0, 0);
        add(1, 0, 0, OP,  0, 0, 0, 0);
        add(1, 1, 0, NOP, 0, 0, 0, 1);
        add(1, 0, 0, OP,  1, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(1, 0, 0, OP, 0, 1, 0, 0);
        add(0, 0, 0, NOP, 0, 0, 1, 0);

        // Saturation with qed_en low, then raise qed_en and drain 127.
        for (int i = 0; i < 200; i++)
            add(0, (i >= 150), 0, OP, 0, 0, 0, (i < 127) ? 7'(i) : 7'd127);
        add(1, 0, 0, OP, 0, 0, 0, 127);
        for (int i = 0; i < 127; i++) add(1, 0, 0, OP, 1, 0, 0, 7'(127 - i));
        for (int i = 0; i < 5; i++) add(1, 0, 0, OP, 0, 1, 0, 0);
        add(1, 0, 0, NOP, 0, 0, 1, 0);
        add(1, 0, 0, NOP, 0, 0, 0, 0);

        // Reset state.
        rst_n = 1'b0;
        drive(0, 0, 1, NOP);
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0);
        $display("reset: exec_dup=%0b hold=%0b ready=%0b pending=%0d",
                 dup_bus.exec_dup, dup_bus.qed_hold, dup_bus.qed_ready, dup_bus.pending_cnt);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].sw, vecs[k].st, vecs[k].instr);
            @(negedge clk);
            check_outs($sformatf("vec%0d", k), vecs[k].ed, vecs[k].hd,
                       vecs[k].rd, vecs[k].pc);
            $display("vec %0d: en=%0b sw=%0b st=%0b op=%h -> exec_dup=%0b hold=%0b ready=%0b pending=%0d",
                     k, vecs[k].en, vecs[k].sw, vecs[k].st, vecs[k].instr[6:0],
                     dup_bus.exec_dup, dup_bus.qed_hold, dup_bus.qed_ready,
                     dup_bus.pending_cnt);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in mid-DUP with pending_cnt=5.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, OP);
            @(posedge clk); #1;
        end
        drive(1, 1, 0, NOP);
        @(posedge clk); #1;
        drive(1, 0, 1, OP);
        @(posedge clk); #1;
        @(negedge clk);
        check_outs("pre_reset_dup", 1, 0, 0, 5);
        $display("pre-reset: exec_dup=%0b pending=%0d", dup_bus.exec_dup, dup_bus.pending_cnt);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 0, 0, 0, 0);
        $display("async reset: exec_dup=%0b hold=%0b ready=%0b pending=%0d",
                 dup_bus.exec_dup, dup_bus.qed_hold, dup_bus.qed_ready, dup_bus.pending_cnt);
        drive(0, 1, 1, OP);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_outs($sformatf("post_reset%0d", i), 0, 0, 0, 0);
            $display("post-reset %0d: exec_dup=%0b pending=%0d", i,
                     dup_bus.exec_dup, dup_bus.pending_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qed_dup_ctrl.md
# qed_dup_ctrl

Mode controller that drives the duplicate-execution side of the QED instruction queue. It tracks original instructions pushed into the queue, decides when to switch fetch into duplicate mode (`exec_dup`), counts replayed instructions out of the queue, then holds fetch while the pipeline drains and pulses `qed_ready` for the consistency checker. It sits between fetch control and the QED instruction queue, and mirrors the queue's insert/delete rules so its pending count always equals queue occupancy.

## Interface
Parameters:
- `MAX_PENDING`, 127: queue capacity in usable entries (7-bit pointers, one slot reserved).
- `DUP_THRESH`, 16: pending count that forces the switch to duplicate mode; legal range 1..`MAX_PENDING`.
- `DRAIN_CYCLES`, 5: cycles fetch is held after the last replay, before `qed_ready`; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `qed_en`  in  1  enables switching into duplicate mode.
- `qed_switch`  in  1  requests an early switch to duplicate mode.
- `IF_stall`  in  1  fetch stall; no insert or delete in a stalled cycle.
- `ifu_qed_instruction`  in  32  fetched instruction; opcode bits [6:0]==7'b1111111 is a NOP.
- `exec_dup`  out  1  duplicate mode; drives the queue's `exec_dup`.
- `qed_hold`  out  1  drain hold; integration ORs this into `IF_stall`.
- `qed_ready`  out  1  one-cycle pulse: originals and duplicates are balanced and the pipeline has drained.
- `pending_cnt`  out  7  current queue occupancy as tracked by this block.

## Operation
- States: ORIG (encoding 0), DUP (1), CHECK (2). All outputs are registered or decoded from state. `exec_dup`=(state==DUP). `qed_hold`=(state==CHECK).
- Insert event (ORIG only): `~IF_stall & ~is_nop & (pending_cnt != MAX_PENDING)`. Increments `pending_cnt`.
- Delete event (DUP only): `~IF_stall & (pending_cnt != 0)`. Decrements `pending_cnt`. In DUP, NOPs count as deletes.
- CHECK performs no insert or delete, whatever `IF_stall` or the instruction is.
- ORIG -> DUP when `qed_en & (pending_cnt != 0) & (qed_switch | pending_cnt >= DUP_THRESH | pending_cnt == MAX_PENDING)`. The condition uses the registered `pending_cnt`. An insert in the same cycle still counts, because the queue inserts while `exec_dup` is 0.
- DUP -> CHECK on a delete event with `pending_cnt==1`. `pending_cnt` becomes 0 on the same edge.
- CHECK: the drain counter loads `DRAIN_CYCLES-1` on entry and decrements every cycle, ignoring stall. When it is 0 in CHECK, the next edge sets `qed_ready`=1 for exactly one cycle and returns to ORIG.
- `qed_en` low: the FSM never leaves ORIG; inserts still count and saturate at `MAX_PENDING`. Deasserting `qed_en` in DUP or CHECK has no effect until the return to ORIG.
- `qed_switch` is ignored outside ORIG and when `pending_cnt`==0.
- Saturation: `pending_cnt` never wraps. Increment is blocked at `MAX_PENDING`, decrement is blocked at 0.

## Timing
- Reset (`rst_n` low, asynchronous, any cycle or state): state ORIG, `exec_dup`=0, `qed_hold`=0, `qed_ready`=0, `pending_cnt`=0, drain counter 0. Takes effect immediately, without a clock edge. The first transition occurs on the first edge after deassertion.
- ORIG->DUP: `exec_dup` rises one cycle after the cycle in which the condition holds.
- The last replay is the delete in cycle N. `qed_hold` is high in cycles N+1 .. N+`DRAIN_CYCLES`. `qed_ready` is high in cycle N+`DRAIN_CYCLES`+1, together with `exec_dup`=0 and `qed_hold`=0.
- Insert and delete never occur in the same cycle; the mode states are exclusive.
- `pending_cnt` updates on the edge that follows its event. It matches the queue pointer difference every cycle.

## Test plan
- Reset mid-DUP with `pending_cnt`=5: assert `rst_n`=0 -> all outputs are 0 immediately. After release, the FSM stays in ORIG with `qed_en`=0.
- `qed_en`=1, `DUP_THRESH`=16, 16 non-stalled non-NOP fetches -> `pending_cnt`=16, `exec_dup`=1 the next cycle. 16 unstalled cycles -> `pending_cnt`=0, `qed_hold` high for 5 cycles, then `qed_ready` pulses once and ORIG resumes.
- Mixed NOPs and stalls in ORIG: 10 fetches, of which 3 are NOP and 2 are stalled -> `pending_cnt`=5. `qed_switch` pulse -> DUP. A stall in DUP delays the final delete by exactly the stall length.
- `qed_en`=0, 200 non-NOP fetches -> `pending_cnt` saturates at 127 and `exec_dup` stays 0. Raise `qed_en` -> DUP the next cycle, then 127 deletes.
- `qed_switch`=1 with `pending_cnt`=0 -> no transition. One insert followed by `qed_switch` -> DUP with 1 delete, then CHECK.
- Fetch in CHECK with `IF_stall`=0 (hold not wired) -> `pending_cnt` unchanged, `qed_ready` still fires at cycle N+6.
